// File: rtl/gencon_n.sv
// gencon_n - parametrised calculator controller.
//
// Takes BCD keypad digits, a sign toggle, an operator and an equals strobe
// from the debouncers, builds two sign-magnitude operands of WIDTH bits and
// computes add/subtract (one cycle), multiply (shift-add) and optionally
// divide (restoring) before presenting the result to the display decoder.
//
// Ports:
//   clk              in  1      rising-edge clock
//   RST              in  1      synchronous active-high reset
//   keypad_input     in  4      BCD digit, 10..15 ignored
//   read_input       in  1      digit strobe, acted on at its rising edge
//   operator_input   in  3      001 sign, 010 add, 011 sub, 100 mul, 101 div
//   equal_input      in  1      equals strobe, acted on at its rising edge
//   display_output   out WIDTH  sign-magnitude value shown
//   complete         out 1      result valid (level while in DONE)
//   overflow         out 1      saturation, divide-by-zero or rejected digit
//   tb_current_state out 3      state encoding for debug
//
// Build option: define GENCON_DIV_EN to include the restoring divider;
// without it operator code 101 is ignored like any illegal code.

module gencon_n #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [3:0]       keypad_input,
    input  logic             read_input,
    input  logic [2:0]       operator_input,
    input  logic             equal_input,
    output logic [WIDTH-1:0] display_output,
    output logic             complete,
    output logic             overflow,
    output logic [2:0]       tb_current_state
);

    localparam int             M       = WIDTH - 1;
    localparam logic [M-1:0]   MAXM    = '1;
    localparam logic [5:0]     STEPS   = 6'(WIDTH - 1);
    localparam logic [WIDTH:0] ONE_W   = 1;
    localparam logic [2:0]     OP_SIGN = 3'b001;
    localparam logic [2:0]     OP_ADD  = 3'b010;
    localparam logic [2:0]     OP_SUB  = 3'b011;
    localparam logic [2:0]     OP_MUL  = 3'b100;
`ifdef GENCON_DIV_EN
    localparam logic [2:0]     OP_DIV  = 3'b101;
`endif

    typedef enum logic [2:0] {
        ENTER_A = 3'd0,
        OP_WAIT = 3'd1,
        COMPUTE = 3'd2,
        ENTER_B = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    // input sampling and edge history
    logic [3:0] key_q;
    logic       read_q, read_prev;
    logic [2:0] op_q, op_prev;
    logic       equal_q, equal_prev;

    // operands, latched operator and result
    logic [M-1:0] mag_a, mag_b, res_mag;
    logic         sign_a, sign_b, res_sign;
    logic         b_entered;
    logic [2:0]   op_code;

    // shift-add multiplier
    logic [2*M-1:0] prod, mcand;
    logic [M-1:0]   mplier;
    logic [5:0]     step_count;

`ifdef GENCON_DIV_EN
    // restoring divider: quotient bits shift in where dividend bits leave
    logic [M-1:0] quo, rem;
    logic [M:0]   rem_shift, rem_sub;
`endif

    // decoded events and per-cycle actions
    logic digit_evt, op_evt, equal_evt, op_is_sign, op_is_arith;
    logic act_digit, act_sign, act_latch, act_start, act_step, act_finish;
    logic act_new, act_chain, act_negate;
    logic compute_done;

    // digit accumulation and add/sub datapath
    logic [M-1:0]   digit_base;
    logic [M+3:0]   digit_ext, digit_next;
    logic           digit_drop;
    logic           sa_eff, sb_eff;
    logic [WIDTH:0] val_a, val_b, sum, sum_abs;
    logic           sum_over, prod_over;
    logic [M-1:0]   shown_mag;
    logic           shown_sign;

    // Events are taken from the registered samples so every action happens
    // one edge after the strobe is first seen high.
    assign digit_evt  = read_q & ~read_prev & (key_q <= 4'd9);
    assign op_evt     = (op_prev == 3'b000) && (op_q != 3'b000);
    assign equal_evt  = equal_q & ~equal_prev;
    assign op_is_sign = (op_q == OP_SIGN);
`ifdef GENCON_DIV_EN
    assign op_is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                         (op_q == OP_MUL) || (op_q == OP_DIV);
`else
    assign op_is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL);
`endif

    // A zero magnitude always carries a positive sign, but the stored sign
    // bit is kept so that "sign, then digits" still yields a negative value.
    assign sa_eff = sign_a & (|mag_a);
    assign sb_eff = sign_b & (|mag_b);

    // Candidate magnitude after appending the current digit (mag*10 + d),
    // computed four bits wider so an out-of-range result is visible.
    always_comb begin
        digit_base = (state == ENTER_B) ? mag_b : mag_a;
        digit_ext  = {4'b0000, digit_base};
        digit_next = (digit_ext << 3) + (digit_ext << 1) + {{M{1'b0}}, key_q};
        digit_drop = (digit_next > {4'b0000, MAXM});
    end

    // Add/subtract in WIDTH+1-bit two's complement, then back to magnitude.
    always_comb begin
        val_a    = sa_eff ? (~{2'b00, mag_a} + ONE_W) : {2'b00, mag_a};
        val_b    = sb_eff ? (~{2'b00, mag_b} + ONE_W) : {2'b00, mag_b};
        sum      = (op_code == OP_SUB) ? (val_a - val_b) : (val_a + val_b);
        sum_abs  = sum[WIDTH] ? (~sum + ONE_W) : sum;
        sum_over = (sum_abs > {2'b00, MAXM});
        prod_over = (prod > {{M{1'b0}}, MAXM});
    end

`ifdef GENCON_DIV_EN
    // One restoring step: a borrow out of the trial subtraction means the
    // divisor did not fit and the shifted remainder is kept.
    always_comb begin
        rem_shift = {rem, quo[M-1]};
        rem_sub   = rem_shift - {1'b0, mag_b};
    end
`endif

    // Add/sub finish in their first COMPUTE cycle; multiply and divide run
    // WIDTH-1 iteration cycles and finish on the following one.
    assign compute_done = (op_code == OP_ADD) || (op_code == OP_SUB) ||
                          (step_count == STEPS);

    // State register.
    always_ff @(posedge clk) begin
        if (RST) begin
            state <= ENTER_A;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and action decode; only one action per edge, chosen in the
    // order equal > operator > digit.
    always_comb begin
        next_state = state;
        act_digit  = 1'b0;
        act_sign   = 1'b0;
        act_latch  = 1'b0;
        act_start  = 1'b0;
        act_step   = 1'b0;
        act_finish = 1'b0;
        act_new    = 1'b0;
        act_chain  = 1'b0;
        act_negate = 1'b0;
        complete   = 1'b0;
        case (state)
            ENTER_A, ENTER_B: begin
                if (equal_evt) begin
                    if (state == ENTER_B) begin
                        act_start  = 1'b1;
                        next_state = COMPUTE;
                    end
                end else if (op_evt && op_is_sign) begin
                    act_sign = 1'b1;
                end else if (op_evt && op_is_arith) begin
                    act_latch  = 1'b1;
                    next_state = ENTER_B;
                end else if (digit_evt) begin
                    act_digit = 1'b1;
                end
            end
            OP_WAIT: begin
                next_state = ENTER_B;
            end
            COMPUTE: begin
                if (compute_done) begin
                    act_finish = 1'b1;
                    next_state = DONE;
                end else begin
                    act_step = 1'b1;
                end
            end
            DONE: begin
                complete = 1'b1;
                if (!equal_evt) begin
                    if (op_evt && op_is_sign) begin
                        act_negate = 1'b1;
                        next_state = ENTER_A;
                    end else if (op_evt && op_is_arith) begin
                        act_chain  = 1'b1;
                        next_state = ENTER_B;
                    end else if (digit_evt) begin
                        act_new    = 1'b1;
                        next_state = ENTER_A;
                    end
                end
            end
            default: begin
                next_state = ENTER_A;
            end
        endcase
    end

    // Input history, operands, sequential arithmetic and flags.
    always_ff @(posedge clk) begin
        if (RST) begin
            key_q      <= '0;
            read_q     <= 1'b0;
            read_prev  <= 1'b0;
            op_q       <= '0;
            op_prev    <= '0;
            equal_q    <= 1'b0;
            equal_prev <= 1'b0;
            mag_a      <= '0;
            mag_b      <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            b_entered  <= 1'b0;
            op_code    <= '0;
            res_mag    <= '0;
            res_sign   <= 1'b0;
            overflow   <= 1'b0;
            prod       <= '0;
            mcand      <= '0;
            mplier     <= '0;
            step_count <= '0;
`ifdef GENCON_DIV_EN
            quo        <= '0;
            rem        <= '0;
`endif
        end else begin
            key_q      <= keypad_input;
            read_q     <= read_input;
            read_prev  <= read_q;
            op_q       <= operator_input;
            op_prev    <= op_q;
            equal_q    <= equal_input;
            equal_prev <= equal_q;

            if (act_digit) begin
                if (digit_drop) begin
                    overflow <= 1'b1;
                end else if (state == ENTER_B) begin
                    mag_b <= digit_next[M-1:0];
                end else begin
                    mag_a    <= digit_next[M-1:0];
                    overflow <= 1'b0;
                end
                if (state == ENTER_B) begin
                    b_entered <= 1'b1;
                end
            end

            if (act_sign) begin
                if (state == ENTER_B) begin
                    sign_b    <= ~sign_b;
                    b_entered <= 1'b1;
                end else begin
                    sign_a <= ~sign_a;
                end
            end

            if (act_latch) begin
                op_code <= op_q;
            end

            if (act_start) begin
                prod       <= '0;
                mcand      <= {{M{1'b0}}, mag_a};
                mplier     <= mag_b;
                step_count <= '0;
`ifdef GENCON_DIV_EN
                quo        <= mag_a;
                rem        <= '0;
`endif
            end

            if (act_step) begin
                step_count <= step_count + 6'd1;
                if (op_code == OP_MUL) begin
                    if (mplier[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end
`ifdef GENCON_DIV_EN
                else if (op_code == OP_DIV) begin
                    if (rem_sub[M]) begin
                        rem <= rem_shift[M-1:0];
                        quo <= {quo[M-2:0], 1'b0};
                    end else begin
                        rem <= rem_sub[M-1:0];
                        quo <= {quo[M-2:0], 1'b1};
                    end
                end
`endif
            end

            if (act_finish) begin
                if (op_code == OP_MUL) begin
                    res_mag  <= prod_over ? MAXM : prod[M-1:0];
                    res_sign <= (sa_eff ^ sb_eff) & (|prod);
                    overflow <= overflow | prod_over;
                end
`ifdef GENCON_DIV_EN
                else if (op_code == OP_DIV) begin
                    if (mag_b == '0) begin
                        res_mag  <= '0;
                        res_sign <= 1'b0;
                        overflow <= 1'b1;
                    end else begin
                        res_mag  <= quo;
                        res_sign <= (sa_eff ^ sb_eff) & (|quo);
                    end
                end
`endif
                else begin
                    res_mag  <= sum_over ? MAXM : sum_abs[M-1:0];
                    res_sign <= sum[WIDTH];
                    overflow <= overflow | sum_over;
                end
            end

            // A fresh digit after a result starts over from a clean slate.
            if (act_new) begin
                mag_a     <= {{(M-4){1'b0}}, key_q};
                sign_a    <= 1'b0;
                mag_b     <= '0;
                sign_b    <= 1'b0;
                b_entered <= 1'b0;
                op_code   <= '0;
                overflow  <= 1'b0;
            end

            // Chaining keeps the result as the new left operand.
            if (act_chain) begin
                mag_a     <= res_mag;
                sign_a    <= res_sign;
                mag_b     <= '0;
                sign_b    <= 1'b0;
                b_entered <= 1'b0;
                op_code   <= op_q;
            end

            if (act_negate) begin
                mag_a     <= res_mag;
                sign_a    <= ~res_sign;
                mag_b     <= '0;
                sign_b    <= 1'b0;
                b_entered <= 1'b0;
            end
        end
    end

    // Display source: B only once the user has started typing it.
    always_comb begin
        shown_mag  = mag_a;
        shown_sign = sign_a;
        case (state)
            ENTER_B, COMPUTE: begin
                if (b_entered) begin
                    shown_mag  = mag_b;
                    shown_sign = sign_b;
                end
            end
            DONE: begin
                shown_mag  = res_mag;
                shown_sign = res_sign;
            end
            default: begin
                shown_mag  = mag_a;
                shown_sign = sign_a;
            end
        endcase
    end

    assign display_output   = {shown_sign & (|shown_mag), shown_mag};
    assign tb_current_state = state;

endmodule

// File: tb/tb_gencon_n.sv
// Testbench for gencon_n: a WIDTH=16 and a WIDTH=8 instance share one set of
// stimulus; expected outputs are queued as each step is driven and popped
// and compared against the selected instance.

module tb_gencon_n;

    localparam int K_DIGIT = 0;
    localparam int K_OP    = 1;
    localparam int K_EQUAL = 2;
    localparam int K_RESET = 3;

    localparam int OP_SIGN = 1;
    localparam int OP_ADD  = 2;
    localparam int OP_SUB  = 3;
    localparam int OP_MUL  = 4;
    localparam int OP_DIV  = 5;

    logic        clk;
    logic        rst;
    logic [3:0]  keypad;
    logic        readIn;
    logic [2:0]  opIn;
    logic        equalIn;

    logic [15:0] disp16;
    logic        cpl16, ovf16;
    logic [2:0]  st16;
    logic [7:0]  disp8;
    logic        cpl8, ovf8;
    logic [2:0]  st8;

    typedef struct {
        string       tag;
        bit          narrow;
        logic [31:0] disp;
        logic        cpl;
        logic        ovf;
        logic [2:0]  st;
    } exp_t;

    exp_t scoreboard[$];
    int   total = 0;
    int   bad   = 0;

    gencon_n #(.WIDTH(16)) dut16 (
        .clk              (clk),
        .RST              (rst),
        .keypad_input     (keypad),
        .read_input       (readIn),
        .operator_input   (opIn),
        .equal_input      (equalIn),
        .display_output   (disp16),
        .complete         (cpl16),
        .overflow         (ovf16),
        .tb_current_state (st16)
    );

    gencon_n #(.WIDTH(8)) dut8 (
        .clk              (clk),
        .RST              (rst),
        .keypad_input     (keypad),
        .read_input       (readIn),
        .operator_input   (opIn),
        .equal_input      (equalIn),
        .display_output   (disp8),
        .complete         (cpl8),
        .overflow         (ovf8),
        .tb_current_state (st8)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle just past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one keypad/operator/equal/reset action.
    task automatic applyStimulus(input int kind, input int value);
        case (kind)
            K_DIGIT: begin
                keypad = value[3:0];
                readIn = 1'b1;
                step(1);
                readIn = 1'b0;
                step(2);
            end
            K_OP: begin
                opIn = value[2:0];
                step(1);
                opIn = 3'b000;
                step(2);
            end
            K_EQUAL: begin
                equalIn = 1'b1;
                step(1);
                equalIn = 1'b0;
            end
            default: begin
                rst = 1'b1;
                step(2);
                rst = 1'b0;
                step(1);
            end
        endcase
    endtask

    // Key a decimal number in most-significant digit first.
    task automatic enterNumber(input int value);
        int digits[$];
        int v;
        v = value;
        if (v == 0) digits.push_back(0);
        while (v > 0) begin
            digits.push_front(v % 10);
            v = v / 10;
        end
        foreach (digits[i]) applyStimulus(K_DIGIT, digits[i]);
    endtask

    task automatic expectOutput(input string tag, input bit narrow, input logic [31:0] disp,
                                input logic cpl, input logic ovf, input logic [2:0] st);
        exp_t e;
        e.tag    = tag;
        e.narrow = narrow;
        e.disp   = disp;
        e.cpl    = cpl;
        e.ovf    = ovf;
        e.st     = st;
        scoreboard.push_back(e);
    endtask

    task automatic compareField(input string tag, input string field,
                                input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("[TB] FAIL %s.%s: got 0x%0h expected 0x%0h", tag, field, got, want);
        end
    endtask

    // Pop every queued expectation and compare against the current outputs.
    task automatic checkOutput();
        exp_t e;
        logic [31:0] gotDisp;
        logic gotCpl, gotOvf;
        logic [2:0] gotSt;
        while (scoreboard.size() != 0) begin
            e = scoreboard.pop_front();
            if (e.narrow) begin
                gotDisp = {24'h0, disp8};
                gotCpl  = cpl8;
                gotOvf  = ovf8;
                gotSt   = st8;
            end else begin
                gotDisp = {16'h0, disp16};
                gotCpl  = cpl16;
                gotOvf  = ovf16;
                gotSt   = st16;
            end
            compareField(e.tag, "display",  gotDisp, e.disp);
            compareField(e.tag, "complete", {31'h0, gotCpl}, {31'h0, e.cpl});
            compareField(e.tag, "overflow", {31'h0, gotOvf}, {31'h0, e.ovf});
            compareField(e.tag, "state",    {29'h0, gotSt},  {29'h0, e.st});
        end
    endtask

    initial begin
        rst     = 1'b0;
        keypad  = 4'd0;
        readIn  = 1'b0;
        opIn    = 3'b000;
        equalIn = 1'b0;

        // reset values on both widths
        applyStimulus(K_RESET, 0);
        expectOutput("reset16", 1'b0, 32'h0, 1'b0, 1'b0, 3'd0);
        expectOutput("reset8",  1'b1, 32'h0, 1'b0, 1'b0, 3'd0);
        checkOutput();

        // 4681 * 7 lands exactly on MAXM: no saturation
        enterNumber(4681);
        expectOutput("enterA", 1'b0, 32'h1249, 1'b0, 1'b0, 3'd0);
        checkOutput();
        applyStimulus(K_OP, OP_MUL);
        expectOutput("mulOp", 1'b0, 32'h1249, 1'b0, 1'b0, 3'd3);
        checkOutput();
        enterNumber(7);
        expectOutput("enterB", 1'b0, 32'h0007, 1'b0, 1'b0, 3'd3);
        checkOutput();
        applyStimulus(K_EQUAL, 0);
        step(1);
        expectOutput("mulBusy", 1'b0, 32'h0007, 1'b0, 1'b0, 3'd2);
        checkOutput();
        step(15);
        expectOutput("mulStill", 1'b0, 32'h0007, 1'b0, 1'b0, 3'd2);
        checkOutput();
        step(1);
        expectOutput("mulDone", 1'b0, 32'h7FFF, 1'b1, 1'b0, 3'd4);
        checkOutput();

        // -25 + -15 = -40, with a signed zero B in between
        applyStimulus(K_RESET, 0);
        applyStimulus(K_OP, OP_SIGN);
        enterNumber(25);
        expectOutput("negA", 1'b0, 32'h8019, 1'b0, 1'b0, 3'd0);
        checkOutput();
        applyStimulus(K_OP, OP_ADD);
        applyStimulus(K_OP, OP_SIGN);
        expectOutput("negZeroB", 1'b0, 32'h0000, 1'b0, 1'b0, 3'd3);
        checkOutput();
        enterNumber(15);
        expectOutput("negB", 1'b0, 32'h800F, 1'b0, 1'b0, 3'd3);
        checkOutput();
        applyStimulus(K_EQUAL, 0);
        step(1);
        expectOutput("addBusy", 1'b0, 32'h800F, 1'b0, 1'b0, 3'd2);
        checkOutput();
        step(1);
        expectOutput("addDone", 1'b0, 32'h8028, 1'b1, 1'b0, 3'd4);
        checkOutput();

        // 200 * 200 saturates; a new digit clears overflow
        applyStimulus(K_RESET, 0);
        enterNumber(200);
        applyStimulus(K_OP, OP_MUL);
        enterNumber(200);
        applyStimulus(K_EQUAL, 0);
        step(17);
        expectOutput("satDone", 1'b0, 32'h7FFF, 1'b1, 1'b1, 3'd4);
        checkOutput();
        applyStimulus(K_DIGIT, 3);
        expectOutput("newA", 1'b0, 32'h0003, 1'b0, 1'b0, 3'd0);
        checkOutput();

        // 8-bit: third digit of 128 is dropped
        applyStimulus(K_RESET, 0);
        enterNumber(128);
        expectOutput("drop8", 1'b1, 32'h0C, 1'b0, 1'b1, 3'd0);
        checkOutput();
        applyStimulus(K_RESET, 0);
        enterNumber(3);
        applyStimulus(K_OP, OP_SUB);
        enterNumber(3);
        applyStimulus(K_EQUAL, 0);
        step(2);
        expectOutput("zero8",  1'b1, 32'h00,   1'b1, 1'b0, 3'd4);
        expectOutput("zero16", 1'b0, 32'h0000, 1'b1, 1'b0, 3'd4);
        checkOutput();

`ifdef GENCON_DIV_EN
        // -100 / 7 truncates toward zero
        applyStimulus(K_RESET, 0);
        applyStimulus(K_OP, OP_SIGN);
        enterNumber(100);
        applyStimulus(K_OP, OP_DIV);
        enterNumber(7);
        applyStimulus(K_EQUAL, 0);
        step(17);
        expectOutput("divDone", 1'b0, 32'h800E, 1'b1, 1'b0, 3'd4);
        checkOutput();
        applyStimulus(K_RESET, 0);
        enterNumber(5);
        applyStimulus(K_OP, OP_DIV);
        enterNumber(0);
        applyStimulus(K_EQUAL, 0);
        step(17);
        expectOutput("divZero", 1'b0, 32'h0000, 1'b1, 1'b1, 3'd4);
        checkOutput();
`else
        // divide code is ignored when the divider is not built
        applyStimulus(K_RESET, 0);
        enterNumber(5);
        applyStimulus(K_OP, OP_DIV);
        expectOutput("divOff", 1'b0, 32'h0005, 1'b0, 1'b0, 3'd0);
        checkOutput();
`endif

        // chaining: (2 + 3) + 4, then negate the result into A
        applyStimulus(K_RESET, 0);
        enterNumber(2);
        applyStimulus(K_OP, OP_ADD);
        enterNumber(3);
        applyStimulus(K_EQUAL, 0);
        step(2);
        expectOutput("chain1", 1'b0, 32'h0005, 1'b1, 1'b0, 3'd4);
        checkOutput();
        applyStimulus(K_OP, OP_ADD);
        expectOutput("chainOp", 1'b0, 32'h0005, 1'b0, 1'b0, 3'd3);
        checkOutput();
        enterNumber(4);
        applyStimulus(K_EQUAL, 0);
        step(2);
        expectOutput("chain2", 1'b0, 32'h0009, 1'b1, 1'b0, 3'd4);
        checkOutput();
        applyStimulus(K_OP, OP_SIGN);
        expectOutput("negate", 1'b0, 32'h8009, 1'b0, 1'b0, 3'd0);
        checkOutput();

        // reset aborts a multiply and clears a pending overflow
        applyStimulus(K_RESET, 0);
        enterNumber(99999);
        expectOutput("drop16", 1'b0, 32'h270F, 1'b0, 1'b1, 3'd0);
        checkOutput();
        applyStimulus(K_OP, OP_MUL);
        enterNumber(9);
        applyStimulus(K_EQUAL, 0);
        step(5);
        expectOutput("midMul", 1'b0, 32'h0009, 1'b0, 1'b1, 3'd2);
        checkOutput();
        rst = 1'b1;
        step(1);
        expectOutput("abort", 1'b0, 32'h0000, 1'b0, 1'b0, 3'd0);
        checkOutput();
        rst = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gencon_n.md
# gencon_n

Parametrised next-generation calculator controller. Accepts BCD keypad digits, a sign toggle, an operator and an equals strobe; accumulates two sign-magnitude operands of configurable width; and computes add, subtract, multiply and (optionally) divide with a sequential datapath. It drives a sign-magnitude display word plus overflow and completion flags. It sits between the keypad/button debouncers and the display decoder, replacing the fixed 16-bit controller.

## Interface
- `WIDTH`, 16: operand/result width in sign-magnitude; bit WIDTH-1 is the sign, so max magnitude is MAXM = 2^(WIDTH-1)-1. Legal range 8..32.
- `clk` in 1: sole clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `keypad_input` in 4: BCD digit; values 10..15 are ignored.
- `read_input` in 1: digit strobe; acted on at its rising edge.
- `operator_input` in 3: 001 sign toggle, 010 add, 011 subtract, 100 multiply, 101 divide, others ignored; acted on when it changes from 000 to nonzero.
- `equal_input` in 1: equals; acted on at its rising edge.
- `display_output` out WIDTH: sign-magnitude value currently shown.
- `complete` out 1: result valid.
- `overflow` out 1: the last result saturated, divide-by-zero occurred, or a digit was rejected.
- `tb_current_state` out 3: state encoding, for debug and benches.

## Operation
- States and encodings:
  - ENTER_A = 0
  - OP_WAIT = 1
  - COMPUTE = 2
  - ENTER_B = 3
  - DONE = 4
- ENTER_A:
  - Digit: mag_a ← mag_a·10 + d.
  - Sign toggle: flips sign_a.
  - Add/sub/mul/div: latches the op and goes to ENTER_B.
- ENTER_B:
  - Digits and sign toggle act on B exactly as in ENTER_A.
  - Further operator codes other than 001 replace the latched op.
  - equal → COMPUTE.
- Digit entry limits:
  - A digit that would make the magnitude exceed MAXM is dropped and sets `overflow`.
  - Operand state is unchanged by a dropped digit.
- COMPUTE:
  - Add/sub: one cycle, in WIDTH+1-bit two's complement of the signed operands.
  - Multiply: shift-add over WIDTH-1 cycles on the magnitudes. Result sign = sign_a XOR sign_b.
  - Divide: restoring division over WIDTH-1 cycles. Quotient truncates toward zero; sign = XOR.
  - After the result is formed, go to DONE.
- Result checks:
  - |result| > MAXM: display MAXM with the correct sign and set `overflow`.
  - Divide by zero: display 0 and set `overflow`.
- DONE:
  - `complete` = 1.
  - Digit: clears everything, starts a new A with that digit, goes to ENTER_A.
  - Add/sub/mul/div (chaining): the result becomes A, B is cleared, goes to ENTER_B.
  - Sign toggle: negates the displayed result and treats it as A in ENTER_A.
- Display source:
  - ENTER_A: A.
  - OP_WAIT: A.
  - ENTER_B: B once any digit or sign is entered, else A.
  - COMPUTE: held value.
  - DONE: result.
- Negative zero: any zero magnitude is forced to sign 0, both on operands and on results.
- `overflow` clears on the next digit accepted in ENTER_A or on RST.
- Inputs arriving during COMPUTE are ignored. Their edge detectors still update, so a level held through COMPUTE does not retrigger.

## Timing
- Reset values:
  - `display_output` = 0
  - `complete` = 0
  - `overflow` = 0
  - `tb_current_state` = ENTER_A
  - Operands, op and edge-detector history cleared
- RST asserted in any state, including mid-multiply, aborts on the next edge.
- Edge detectors register the previous input value. An action is taken on the clock edge after the input rises, and the new display is visible one cycle later.
- Equal sampled in ENTER_B at edge N:
  - COMPUTE at N+1.
  - Add/sub: DONE with `complete` = 1 at N+2.
  - Multiply/divide: DONE at N+1+WIDTH.
- `complete` is a level, held for the whole of DONE; it drops on the edge that leaves DONE.
- Simultaneous events at one edge, priority: RST > equal > operator > digit.

## Configuration
- `GENCON_DIV_EN` defined: operator 101 selects the restoring divider.
- `GENCON_DIV_EN` undefined: the divider is not synthesised and 101 is ignored like any other illegal code. All other behaviour is identical.

## Test plan
- WIDTH=16: 4681, mul, 7, equal → after 17 cycles `display_output` = 0x7FFF, `complete` = 1, `overflow` = 0.
- WIDTH=16: −25 (sign then 2,5), add, −15 (sign, 1,5), equal → 0x8028 (−40) two cycles after equal.
- WIDTH=16: 200 mul 200 → 0x7FFF, `overflow` = 1; then digit 3 → state ENTER_A, display 3, `overflow` = 0.
- WIDTH=8: entering 1,2,8 → third digit dropped, display 12, `overflow` = 1; then 3 sub 3 → display 0x00 (no negative zero).
- With `GENCON_DIV_EN`: −100 div 7 → 0x800E (−14). 5 div 0 → 0, `overflow` = 1. Without the macro, 101 leaves the state at ENTER_A.
- Chaining: 2 add 3 equal (5), then add, 4, equal → 9. RST asserted mid-multiply → state 0 and all outputs 0 next cycle.
